ysyx_23060236_axi_sram: RTL
===========================

# ysyx_23060236_axi_sram

AXI4 responder (slave) with a word-addressed register-array memory, the far end of the crossbar's SoC master port. It accepts single-beat writes with byte strobes and single or burst reads (FIXED/INCR, up to 16 beats), with configurable read latency. It is used as a behavioural memory for the NPC simulation top and as a checked endpoint for crossbar and LSU verification.

## Interface
- ADDR_W, 12, log2 of memory depth in 32-bit words; word index = addr[ADDR_W+1:2]; upper address bits ignored (aliasing).
- LATENCY, 1, cycles from AR handshake edge to first rvalid; legal range 1..15.
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- awready  out  1  AW accept
- awvalid  in  1  AW valid
- awaddr  in  32  write byte address, word-aligned
- wready  out  1  W accept
- wvalid  in  1  W valid
- wdata  in  32  write data
- wstrb  in  4  byte enables, bit i -> wdata[8i+7:8i]
- bready  in  1  B accept
- bvalid  out  1  write response valid
- bresp  out  2  always OKAY (2'b00)
- arready  out  1  AR accept
- arvalid  in  1  AR valid
- araddr  in  32  read byte address, word-aligned
- arlen  in  4  beats minus one
- arburst  in  2  00 FIXED, 01 INCR, 10 treated as INCR, 11 reserved
- rready  in  1  R accept
- rvalid  out  1  read data valid
- rresp  out  2  OKAY, or SLVERR (2'b10) for reserved burst
- rdata  out  32  read data
- rlast  out  1  high on final beat only

## Operation
- States: IDLE, WR_RESP, RD_WAIT, RD_DATA.
- IDLE: awready = wready = awvalid & wvalid (write needs both channels in same cycle); arready = ~(awvalid & wvalid). Write has priority over read.
- Write handshake: bytes selected by wstrb written at clock edge; -> WR_RESP. WR_RESP: bvalid=1 until bready, then -> IDLE.
- Read handshake: latch word index, arlen, burst, error flag (arburst==11); beat counter=0; -> RD_WAIT with delay counter = LATENCY-1 (LATENCY=1 goes straight to RD_DATA).
- RD_DATA: rvalid=1; rdata = mem[index] (0 on error); rresp = error ? SLVERR : OKAY; rlast = (beat==arlen). On rready: if rlast -> IDLE, else beat+1 and index+1 (INCR, wraps modulo 2^ADDR_W) or unchanged (FIXED); rvalid stays high next cycle.
- No new request accepted outside IDLE; arready/awready/wready low in all other states.

## Timing
- Reset values: awready 0, wready 0, bvalid 0, arready 0, rvalid 0, rlast 0, rresp 0, bresp 0, rdata 0; state IDLE. Memory contents not reset.
- Write: B valid the cycle after W handshake; read-after-write to same address returns new data.
- Read: first rvalid LATENCY cycles after AR handshake; subsequent beats back-to-back (1 beat/cycle) while rready high.
- rready low: rvalid, rdata, rresp, rlast held stable.
- Reset asserted mid-burst or mid-response: outputs drop to reset values asynchronously; transaction abandoned, no B/R completion.

## Configuration
- YSYX_23060236_SRAM_RAND_DELAY_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h5A on reset) advances every cycle; lfsr[1:0] extra cycles (0..3) inserted before each R beat's rvalid and before bvalid; ordering and data unchanged.
- Undefined: fixed timing exactly as above; no LFSR logic.

## Structure
- Shared package/defines: resp codes (OKAY 2'b00, SLVERR 2'b10), burst codes (FIXED 2'b00, INCR 2'b01, RSVD 2'b11), state encoding.
- One sub-module: ysyx_23060236_lfsr8, instantiated only under the macro.

## Test plan
- Write 32'hDEADBEEF, wstrb 4'hF to 0x100; read arlen=0 -> rdata DEADBEEF, rresp 0, rlast 1, rvalid exactly LATENCY cycles after AR.
- Write 32'h11223344 to 0x200, then 32'hAABBCCDD wstrb 4'b0101 -> read returns 32'h11BB33DD.
- Fill words 0..3 with 0..3; INCR arlen=3 from 0x0, rready low 2 cycles on beat 2 -> data 0,1,2,3, beat 2 held stable, rlast on 4th only; FIXED arlen=3 from 0x4 -> 1,1,1,1.
- awvalid, wvalid, arvalid high together in IDLE -> write accepted, arready 0; AR accepted after B handshake, returns written data.
- arburst=2'b11, arlen=1 -> two beats, rresp 2'b10, rdata 0, rlast on second.
- Reset pulled low during beat 2 of arlen=7 burst -> rvalid 0 immediately; after release, read of any prior address returns previously written data.

Source files
------------

// File: rtl/ysyx_23060236_axi_sram_pkg.sv
// Shared AXI response/burst codes and FSM state encoding for the AXI SRAM responder.
package ysyx_23060236_axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_RESP = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_DATA = 2'd3
  } sram_state_e;

endpackage

// File: rtl/ysyx_23060236_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'h5A; only built when
// YSYX_23060236_SRAM_RAND_DELAY_EN is defined.
`ifdef YSYX_23060236_SRAM_RAND_DELAY_EN
module ysyx_23060236_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_o = lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 8'h5A;
    else         lfsr_q <= {lfsr_q[6:0], fb};
  end

endmodule
`endif

// File: rtl/ysyx_23060236_axi_sram.sv
// AXI4 responder backed by a word-addressed register array: single-beat writes
// with strobes, FIXED/INCR read bursts with LATENCY-cycle first-beat delay.
// YSYX_23060236_SRAM_RAND_DELAY_EN adds LFSR-driven 0..3 cycle gaps before
// each R beat and before B.
module ysyx_23060236_axi_sram #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        awready,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        wready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        bready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  output logic        arready,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        rlast
);
  import ysyx_23060236_axi_sram_pkg::*;

  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  logic [31:0]       mem_q [2**ADDR_W];
  sram_state_e       state_q;
  logic [ADDR_W-1:0] idx_q, idx_d, ld_idx, aw_idx, ar_idx;
  logic [3:0]        len_q, beat_q, wait_q;
  logic              fixed_q, err_q;
  logic [1:0]        dly_q, gap;
  logic              bvalid_q, rvalid_q, rlast_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rdata_q, ld_data;
  logic              ld_err, ld_last;
  logic              idle, both_aw_w, wr_go, rd_go;
  logic              unused_addr;

  assign aw_idx      = awaddr[ADDR_W+1:2];
  assign ar_idx      = araddr[ADDR_W+1:2];
  assign unused_addr = ^{awaddr[31:ADDR_W+2], awaddr[1:0],
                         araddr[31:ADDR_W+2], araddr[1:0]};

`ifdef YSYX_23060236_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;

  ysyx_23060236_lfsr8 u_lfsr (
    .clk_i  (clock),
    .rst_ni (reset),
    .lfsr_o (lfsr)
  );
  assign gap         = lfsr[1:0];
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign gap = '0;
`endif

  // Ready terms are gated by reset so they read 0 while reset is held.
  assign idle      = reset & (state_q == ST_IDLE);
  assign both_aw_w = awvalid & wvalid;
  assign wr_go     = idle & both_aw_w;
  assign rd_go     = idle & arvalid & ~both_aw_w;

  assign awready = wr_go;
  assign wready  = wr_go;
  assign arready = idle & ~both_aw_w;
  assign bvalid  = bvalid_q;
  assign bresp   = RESP_OKAY;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign rlast   = rlast_q;

  always_ff @(posedge clock) begin
    if (wr_go) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[aw_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // The beat about to be presented: from AR (LATENCY=1), from the latched
  // start index (end of wait), or the next index within the burst.
  always_comb begin
    idx_d   = fixed_q ? idx_q : idx_q + ADDR_W'(1);
    ld_idx  = idx_d;
    ld_err  = err_q;
    ld_last = (beat_q + 4'd1) == len_q;
    if (state_q == ST_IDLE) begin
      ld_idx  = ar_idx;
      ld_err  = arburst == BURST_RSVD;
      ld_last = arlen == 4'd0;
    end else if (state_q == ST_RD_WAIT) begin
      ld_idx  = idx_q;
      ld_last = len_q == 4'd0;
    end
    ld_data = ld_err ? '0 : mem_q[ld_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      dly_q    <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (wr_go) begin
            state_q  <= ST_WR_RESP;
            bvalid_q <= gap == 2'd0;
            dly_q    <= gap;
          end else if (rd_go) begin
            idx_q   <= ar_idx;
            len_q   <= arlen;
            beat_q  <= '0;
            fixed_q <= arburst == BURST_FIXED;
            err_q   <= arburst == BURST_RSVD;
            if (LATENCY <= 1) begin
              state_q  <= ST_RD_DATA;
              rvalid_q <= gap == 2'd0;
              dly_q    <= gap;
              rdata_q  <= ld_data;
              rresp_q  <= ld_err ? RESP_SLVERR : RESP_OKAY;
              rlast_q  <= ld_last;
            end else begin
              state_q <= ST_RD_WAIT;
              wait_q  <= WAIT_INIT;
            end
          end
        end
        ST_WR_RESP: begin
          if (!bvalid_q) begin
            if (dly_q <= 2'd1) bvalid_q <= 1'b1;
            else               dly_q    <= dly_q - 2'd1;
          end else if (bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (wait_q <= 4'd1) begin
            state_q  <= ST_RD_DATA;
            rvalid_q <= gap == 2'd0;
            dly_q    <= gap;
            rdata_q  <= ld_data;
            rresp_q  <= ld_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q  <= ld_last;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (!rvalid_q) begin
            if (dly_q <= 2'd1) rvalid_q <= 1'b1;
            else               dly_q    <= dly_q - 2'd1;
          end else if (rready) begin
            if (rlast_q) begin
              state_q  <= ST_IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              rresp_q  <= RESP_OKAY;
              rdata_q  <= '0;
            end else begin
              beat_q   <= beat_q + 4'd1;
              idx_q    <= idx_d;
              rvalid_q <= gap == 2'd0;
              dly_q    <= gap;
              rdata_q  <= ld_data;
              rresp_q  <= ld_err ? RESP_SLVERR : RESP_OKAY;
              rlast_q  <= ld_last;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
